// File: rtl/elevator_car_ctrl.sv
// Car motion/dispatch controller: latches hall/car calls, moves one floor per CLK_PER_FLOOR+1 cycles, and drives the door controller.
// Optional idle parking to floor 1 is built when ELEV_PARK_EN is defined.
module elevator_car_ctrl #(
    parameter int CLK_PER_FLOOR = 100000000,
    parameter int DOOR_TIMEOUT  = 1000,
    parameter int PARK_CYCLES   = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:1] hallUp,
    input  logic [7:1] hallDown,
    input  logic [7:1] carButton,
    input  logic       doorState,
    output logic [2:0] currentFloor,
    output logic [1:0] currentDirection,
    output logic [1:0] currentFloorButton,
    output logic       doorHold,
    output logic [7:1] pendCar,
    output logic [7:1] pendUp,
    output logic [7:1] pendDown
);

    typedef enum logic [1:0] {IDLE, MOVE, SERVE, DEPART} state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    state_t      state, state_n;
    logic [2:0]  floor;
    logic [1:0]  dir, dir_n;
    logic [7:1]  pend_car, pend_up, pend_dn;
    logic [7:1]  clr_car, clr_up, clr_dn;
    logic [31:0] travel_cnt;
    logic        boundary;
    logic        seen_open;
    logic [31:0] door_cnt;
    logic        park_quiet;

    logic [7:1] all_pend, above_mask, below_mask;
    logic       req_above, req_below, ahead, behind;
    logic       at_car, at_up, at_dn, at_any, match_hall, opp_hall;
    logic [1:0] at_floor_dir, flip_dir;

    always_comb begin
        all_pend = pend_car | pend_up | pend_dn;
        for (int i = 1; i <= 7; i++) begin
            above_mask[i] = 3'(i) > floor;
            below_mask[i] = 3'(i) < floor;
        end
        req_above  = |(all_pend & above_mask);
        req_below  = |(all_pend & below_mask);
        at_car     = pend_car[floor];
        at_up      = pend_up[floor];
        at_dn      = pend_dn[floor];
        at_any     = at_car | at_up | at_dn;
        ahead      = (dir == DIR_UP) ? req_above : (dir == DIR_DOWN) ? req_below : 1'b0;
        behind     = (dir == DIR_UP) ? req_below : (dir == DIR_DOWN) ? req_above : 1'b0;
        match_hall = (dir == DIR_UP) ? at_up : (dir == DIR_DOWN) ? at_dn : 1'b0;
        opp_hall   = (dir == DIR_UP) ? at_dn : (dir == DIR_DOWN) ? at_up : 1'b0;
        flip_dir   = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
        if (floor == 3'd7)
            at_floor_dir = DIR_DOWN;
        else if (floor == 3'd1)
            at_floor_dir = DIR_UP;
        else
            at_floor_dir = (at_up | at_car) ? DIR_UP : DIR_DOWN;
    end

`ifdef ELEV_PARK_EN
    logic        park;
    logic [31:0] idle_cnt;

    always_comb park_quiet = park && (all_pend == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            park     <= 1'b0;
            idle_cnt <= '0;
        end else begin
            // Only the park branch leaves IDLE for MOVE with nothing above or below.
            if (state == IDLE && state_n == MOVE && !req_above && !req_below)
                park <= 1'b1;
            else if (state_n != MOVE)
                park <= 1'b0;
            if (state == IDLE && floor != 3'd1 && all_pend == '0)
                idle_cnt <= idle_cnt + 32'd1;
            else
                idle_cnt <= '0;
        end
    end
`else
    always_comb park_quiet = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        case (state)
            IDLE: begin
                if (at_any) begin
                    state_n = SERVE;
                    dir_n   = at_floor_dir;
                end else if (req_above) begin
                    state_n = MOVE;
                    dir_n   = DIR_UP;
                end else if (req_below) begin
                    state_n = MOVE;
                    dir_n   = DIR_DOWN;
                end
`ifdef ELEV_PARK_EN
                else if (floor != 3'd1 && idle_cnt == 32'(PARK_CYCLES - 1)) begin
                    state_n = MOVE;
                    dir_n   = DIR_DOWN;
                end
`endif
            end
            MOVE: begin
                if (boundary) begin
                    if (park_quiet) begin
                        if (floor == 3'd1) begin
                            state_n = IDLE;
                            dir_n   = DIR_STOP;
                        end
                    end else if (at_car || match_hall || !ahead) begin
                        state_n = SERVE;
                        if (!ahead && !at_car && !match_hall && opp_hall)
                            dir_n = flip_dir;
                    end
                end
            end
            SERVE: begin
                if (seen_open) begin
                    if (!doorState)
                        state_n = DEPART;
                end else if (!doorState && door_cnt == 32'(DOOR_TIMEOUT - 1)) begin
                    state_n = DEPART;
                end
            end
            DEPART: begin
                if (ahead) begin
                    state_n = MOVE;
                end else if (behind) begin
                    state_n = MOVE;
                    dir_n   = flip_dir;
                end else if (at_any) begin
                    // Turn round if only the opposite hall call remains, else it could never clear.
                    state_n = SERVE;
                    if (!at_car && !match_hall)
                        dir_n = flip_dir;
                end else begin
                    state_n = IDLE;
                    dir_n   = DIR_STOP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        clr_car = '0;
        clr_up  = '0;
        clr_dn  = '0;
        if (state == SERVE && doorState) begin
            clr_car[floor] = 1'b1;
            if (dir == DIR_UP)
                clr_up[floor] = 1'b1;
            else
                clr_dn[floor] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            floor      <= 3'd1;
            dir        <= DIR_STOP;
            pend_car   <= '0;
            pend_up    <= '0;
            pend_dn    <= '0;
            travel_cnt <= '0;
            boundary   <= 1'b0;
            seen_open  <= 1'b0;
            door_cnt   <= '0;
        end else begin
            dir      <= dir_n;
            // New presses win over a same-cycle clear.
            pend_car <= (pend_car & ~clr_car) | carButton;
            pend_up  <= (pend_up & ~clr_up) | (hallUp & 7'b0111111);
            pend_dn  <= (pend_dn & ~clr_dn) | (hallDown & 7'b1111110);

            if (state_n == MOVE && state != MOVE) begin
                travel_cnt <= 32'(CLK_PER_FLOOR - 1);
                boundary   <= 1'b0;
            end else if (state == MOVE) begin
                if (!boundary) begin
                    if (travel_cnt == '0) begin
                        boundary <= 1'b1;
                        if (dir == DIR_UP && floor != 3'd7)
                            floor <= floor + 3'd1;
                        else if (dir == DIR_DOWN && floor != 3'd1)
                            floor <= floor - 3'd1;
                    end else begin
                        travel_cnt <= travel_cnt - 32'd1;
                    end
                end else begin
                    boundary   <= 1'b0;
                    travel_cnt <= 32'(CLK_PER_FLOOR - 1);
                end
            end

            if (state_n == SERVE && state != SERVE) begin
                seen_open <= 1'b0;
                door_cnt  <= '0;
            end else if (state == SERVE) begin
                if (doorState)
                    seen_open <= 1'b1;
                else if (!seen_open)
                    door_cnt <= door_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        doorHold           = reset || (state == MOVE);
        currentFloor       = floor;
        currentDirection   = dir;
        currentFloorButton = {pend_dn[floor], pend_up[floor]};
        pendCar            = pend_car;
        pendUp             = pend_up;
        pendDown           = pend_dn;
    end

endmodule
